// File: rtl/u_rx_pkg.sv
// Shared UART receive definitions: FSM state encodings and line constants.
package u_rx_pkg;

    // 3-bit state encoding, values shared with the transmit side.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4
    } rx_state_e;

    // Idle (mark) level of the serial line.
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/u_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module u_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; reset to the line's idle level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/u_rx.sv
// UART receiver: 1 start bit, width data bits LSB first, 1 stop bit, no parity.
// The line is oversampled at no_of_sample ticks per bit and sampled at mid-bit.
module u_rx
    import u_rx_pkg::*;
#(
    parameter int unsigned width        = 8,
    parameter int unsigned no_of_sample = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_data_in,
    input  logic             baud_en_rx,
    output logic [width-1:0] data_out,
    output logic             rx_done,
    output logic             frame_err,
    output logic             rx_active
);

    localparam int unsigned SMP_W = $clog2(no_of_sample);
    localparam int unsigned BIT_W = $clog2(width);

    localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(no_of_sample / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(no_of_sample - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(width - 1);

    logic rxs;

    rx_state_e        state_q,   state_d;
    logic [SMP_W-1:0] smp_q,     smp_d;
    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    logic [width-1:0] sh_q,      sh_d;
    logic [width-1:0] data_q,    data_d;
    logic             done_q,    done_d;
    logic             ferr_q,    ferr_d;
    logic             active_q,  active_d;

    u_sync2 #(
        .RESET_VAL (LINE_IDLE)
    ) u_sync2_rx (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (rx_data_in),
        .q_o   (rxs)
    );

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            smp_q     <= '0;
            bit_idx_q <= '0;
            sh_q      <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            bit_idx_q <= bit_idx_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            active_q  <= active_d;
        end
    end

    // Next-state logic: start detect on any clk, all sampling gated by the baud tick.
    always_comb begin
        state_d   = state_q;
        smp_d     = smp_q;
        bit_idx_d = bit_idx_q;
        sh_d      = sh_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = ferr_q;
        active_d  = active_q;

        unique case (state_q)
            ST_IDLE: begin
                active_d = 1'b0;
                if (!rxs) begin
                    state_d  = ST_START;
                    smp_d    = '0;
                    active_d = 1'b1;
                end
            end
            ST_START: begin
                if (baud_en_rx) begin
                    if (smp_q == SMP_MID) begin
                        smp_d = '0;
                        if (!rxs) begin
                            state_d   = ST_DATA;
                            bit_idx_d = '0;
                        end else begin
                            // Line back high at mid start bit: treat as a glitch.
                            state_d  = ST_IDLE;
                            active_d = 1'b0;
                        end
                    end else begin
                        smp_d = smp_q + SMP_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (baud_en_rx) begin
                    if (smp_q == SMP_LAST) begin
                        sh_d  = {rxs, sh_q[width-1:1]};
                        smp_d = '0;
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + BIT_W'(1);
                        end
                    end else begin
                        smp_d = smp_q + SMP_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (baud_en_rx) begin
                    if (smp_q == SMP_LAST) begin
                        // Word is published even on a framing error.
                        data_d  = sh_q;
                        ferr_d  = ~rxs;
                        done_d  = 1'b1;
                        smp_d   = '0;
                        state_d = ST_CLEANUP;
                    end else begin
                        smp_d = smp_q + SMP_W'(1);
                    end
                end
            end
            ST_CLEANUP: begin
                active_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    assign data_out  = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_active = active_q;

endmodule

// File: tb/tb_u_rx.sv
// Directed testbench for the u_rx UART receiver.
module tb_u_rx;

    localparam int NS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic       baud_en = 1'b0;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic       rx_active;

    int         checks = 0;
    int         failures = 0;
    int         tick_div = 0;
    int         done_cnt = 0;
    int         base;
    logic [7:0] got_data [64];
    logic       got_ferr [64];
    logic [7:0] exp_b    [16];
    logic [7:0] f0;

    u_rx #(
        .width        (8),
        .no_of_sample (NS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data_in (rx_line),
        .baud_en_rx (baud_en),
        .data_out   (data_out),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .rx_active  (rx_active)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk in every four.
    always @(posedge clk) begin
        tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
        baud_en  <= (tick_div == 2);
    end

    // Record every cycle rx_done is high, with the word and flag it carries.
    always @(posedge clk) begin
        if (rx_done) begin
            got_data[done_cnt[5:0]] <= data_out;
            got_ferr[done_cnt[5:0]] <= frame_err;
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!baud_en) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic b, input int n);
        rx_line = b;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len);
        send_bit(1'b0, NS);
        for (int i = 0; i < 8; i++) send_bit(d[i], NS);
        send_bit(stop_v, stop_len);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_out, 8'h00);
        check("rst_done", rx_done, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_active", rx_active, 1'b0);
        rst = 1'b0;
        wait_ticks(4);

        // 1: good frame 0xA5
        base = done_cnt;
        send_bit(1'b0, NS);
        check("t1_active_mid", rx_active, 1'b1);
        f0 = 8'hA5;
        for (int i = 0; i < 8; i++) send_bit(f0[i], NS);
        send_bit(1'b1, NS);
        wait_ticks(NS);
        check("t1_count", done_cnt - base, 1);
        check("t1_got", got_data[base], 8'hA5);
        check("t1_gotferr", got_ferr[base], 1'b0);
        check("t1_data", data_out, 8'hA5);
        check("t1_ferr", frame_err, 1'b0);
        check("t1_active_end", rx_active, 1'b0);

        // 2: short low glitch is rejected at mid start bit
        base = done_cnt;
        rx_line = 1'b0;
        wait_ticks(3);
        check("t2_active_glitch", rx_active, 1'b1);
        rx_line = 1'b1;
        wait_ticks(12);
        check("t2_active_end", rx_active, 1'b0);
        check("t2_count", done_cnt - base, 0);
        check("t2_data", data_out, 8'hA5);

        // 3: stop bit low -> framing error; line returned high before the re-detect sample
        base = done_cnt;
        send_frame(8'h3C, 1'b0, 12);
        rx_line = 1'b1;
        wait_ticks(24);
        check("t3_count", done_cnt - base, 1);
        check("t3_got", got_data[base], 8'h3C);
        check("t3_gotferr", got_ferr[base], 1'b1);
        check("t3_ferr_held", frame_err, 1'b1);
        check("t3_data", data_out, 8'h3C);
        check("t3_active", rx_active, 1'b0);
        base = done_cnt;
        send_frame(8'h11, 1'b1, NS);
        wait_ticks(8);
        check("t3b_count", done_cnt - base, 1);
        check("t3b_data", data_out, 8'h11);
        check("t3b_ferr", frame_err, 1'b0);

        // 4: back-to-back frames, no idle gap
        base = done_cnt;
        send_frame(8'h00, 1'b1, NS);
        send_frame(8'hFF, 1'b1, NS);
        send_frame(8'h55, 1'b1, NS);
        wait_ticks(4);
        check("t4_count", done_cnt - base, 3);
        check("t4_d0", got_data[base], 8'h00);
        check("t4_d1", got_data[base+1], 8'hFF);
        check("t4_d2", got_data[base+2], 8'h55);
        check("t4_f0", got_ferr[base], 1'b0);
        check("t4_f1", got_ferr[base+1], 1'b0);
        check("t4_f2", got_ferr[base+2], 1'b0);

        // 5: reset during bit 4 of 0xF0
        base = done_cnt;
        send_bit(1'b0, NS);
        for (int i = 0; i < 4; i++) send_bit(1'b0, NS);
        send_bit(1'b1, 8);
        check("t5_active_pre", rx_active, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_rst_data", data_out, 8'h00);
        check("t5_rst_active", rx_active, 1'b0);
        check("t5_rst_done", rx_done, 1'b0);
        check("t5_rst_ferr", frame_err, 1'b0);
        rx_line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ticks(2 * NS);
        check("t5_no_done", done_cnt - base, 0);
        base = done_cnt;
        send_frame(8'h81, 1'b1, NS);
        wait_ticks(4);
        check("t5_count", done_cnt - base, 1);
        check("t5_data", data_out, 8'h81);
        check("t5_ferr", frame_err, 1'b0);

        // 6: random bytes back-to-back
        base = done_cnt;
        for (int k = 0; k < 16; k++) begin
            exp_b[k] = 8'($urandom_range(0, 255));
            send_frame(exp_b[k], 1'b1, NS);
        end
        wait_ticks(4);
        check("t6_count", done_cnt - base, 16);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t6_d%0d", k), got_data[base+k], exp_b[k]);
            check($sformatf("t6_f%0d", k), got_ferr[base+k], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
